// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: FSM state encoding and the
// gate-window length computation.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        LATCH = 2'd2
    } state_t;

    // Number of system clocks in one gate window; divide first so the
    // intermediate product stays small for large clock frequencies.
    function automatic int unsigned gate_cycles(input int unsigned input_freq,
                                                input int unsigned gate_ms);
        return input_freq / 1000 * gate_ms;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector for an
// asynchronous level input (signal, button or sensor line).
module edge_sync (
    input  logic clk_in,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic meta;
    logic s;
    logic s_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, forming a true shift chain.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            meta   <= 1'b0;
            s      <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            meta   <= d;
            s      <= meta;
            s_prev <= s;
        end
    end

    assign rise = s & ~s_prev;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over
// a GATE_CYCLES-long window and publishes the count with a valid strobe.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned INPUT_FREQ  = 50000000,
    parameter int unsigned GATE_MS     = 1000,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   sig_in,
    output logic [COUNT_WIDTH-1:0] freq_count,
    output logic                   valid,
    output logic                   overflow,
    output logic                   busy
);

    localparam int unsigned      GATE_CYCLES = gate_cycles(INPUT_FREQ, GATE_MS);
    localparam int               GATE_W      = $clog2(GATE_CYCLES + 1);
    localparam logic [GATE_W-1:0] GATE_LAST  = GATE_W'(GATE_CYCLES - 1);

    state_t                 state;
    state_t                 state_next;
    logic [GATE_W-1:0]      gate_cnt;
    logic [COUNT_WIDTH-1:0] edge_cnt;
    logic                   sat_flag;
    logic                   rise;

    edge_sync u_sync (
        .clk_in (clk_in),
        .reset  (reset),
        .d      (sig_in),
        .rise   (rise)
    );

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: state_next gets its default before the case so no path through
    // this block leaves it unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = COUNT;
            COUNT: begin
                if (!enable)                  state_next = IDLE;
                else if (gate_cnt == GATE_LAST) state_next = LATCH;
            end
            LATCH:   state_next = enable ? COUNT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counters run only in COUNT; IDLE and LATCH hold them cleared, so an
    // aborted window simply discards its partial count.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat_flag <= 1'b0;
        end else if (state == COUNT) begin
            gate_cnt <= gate_cnt + 1'b1;
            if (rise) begin
                if (&edge_cnt) sat_flag <= 1'b1;
                else           edge_cnt <= edge_cnt + 1'b1;
            end
        end else begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat_flag <= 1'b0;
        end
    end

    // Results load on the LATCH edge; valid is registered alongside them so
    // the strobe and the new value are seen by consumers in the same cycle.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            freq_count <= '0;
            overflow   <= 1'b0;
            valid      <= 1'b0;
        end else begin
            valid <= (state == LATCH);
            if (state == LATCH) begin
                freq_count <= edge_cnt;
                overflow   <= sat_flag;
            end
        end
    end

    assign busy = (state == COUNT);

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a 16-bit and a 3-bit counter instance share
// clock, reset, enable and sig_in; window results come from a vector table.
module tb_freq_meter;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        enable;
    logic        sig_in;

    logic [15:0] fc16;
    logic        v16, o16, b16;
    logic [2:0]  fc3;
    logic        v3, o3, b3;

    int period = 10;
    int ph     = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int period;
        int exp16;
        int exp3;
        int ovf3;
    } vec_t;

    vec_t vecs[8];

    freq_meter #(.INPUT_FREQ(10000), .GATE_MS(10), .COUNT_WIDTH(16)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .enable     (enable),
        .sig_in     (sig_in),
        .freq_count (fc16),
        .valid      (v16),
        .overflow   (o16),
        .busy       (b16)
    );

    freq_meter #(.INPUT_FREQ(10000), .GATE_MS(10), .COUNT_WIDTH(3)) dut_s (
        .clk_in     (clk_in),
        .reset      (reset),
        .enable     (enable),
        .sig_in     (sig_in),
        .freq_count (fc3),
        .valid      (v3),
        .overflow   (o3),
        .busy       (b3)
    );

    always #5 clk_in = ~clk_in;

    // Square-wave source: high for period/2 clocks, low for the rest; 0 = held low.
    initial begin
        sig_in = 1'b0;
        forever begin
            @(negedge clk_in);
            if (period == 0) begin
                ph     = 0;
                sig_in = 1'b0;
            end else begin
                ph     = (ph + 1 >= period) ? 0 : ph + 1;
                sig_in = (ph < period / 2);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!v16 && n < 400);
        check({name, "_valid_seen"}, 32'(v16), 1);
    endtask

    // Release reset just after sig_in falls so the cleared synchronizer
    // matches the real input level and no phantom edge appears.
    task automatic release_aligned();
        for (int i = 0; i < 60; i++) begin
            tick();
            #1;
            if (period != 0 && ph == period / 2) break;
        end
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_fc16"}, 32'(fc16), 0);
        check({name, "_v16"},  32'(v16),  0);
        check({name, "_o16"},  32'(o16),  0);
        check({name, "_b16"},  32'(b16),  0);
        check({name, "_fc3"},  32'(fc3),  0);
        check({name, "_o3"},   32'(o3),   0);
    endtask

    initial begin
        int n;
        logic seen;

        vecs[0] = '{period: 10,  exp16: 10, exp3: 7, ovf3: 1};
        vecs[1] = '{period: 20,  exp16: 5,  exp3: 5, ovf3: 0};
        vecs[2] = '{period: 0,   exp16: 0,  exp3: 0, ovf3: 0};
        vecs[3] = '{period: 4,   exp16: 25, exp3: 7, ovf3: 1};
        vecs[4] = '{period: 25,  exp16: 4,  exp3: 4, ovf3: 0};
        vecs[5] = '{period: 50,  exp16: 2,  exp3: 2, ovf3: 0};
        vecs[6] = '{period: 100, exp16: 1,  exp3: 1, ovf3: 0};
        vecs[7] = '{period: 10,  exp16: 10, exp3: 7, ovf3: 1};

        // Reset state, first window after release, continuous strobing
        reset  = 1'b1;
        enable = 1'b1;
        period = 10;
        repeat (3) tick();
        check_reset_outputs("rst");
        release_aligned();
        tick();
        check("rst_busy_after_release", 32'(b16), 1);
        wait_valid("w1", n);
        check("w1_cycles", n, 101);
        check("w1_fc16", 32'(fc16), 10);
        check("w1_o16",  32'(o16),  0);
        wait_valid("w2", n);
        check("w2_cycles", n, 101);
        check("w2_fc16", 32'(fc16), 10);
        tick();
        check("valid_one_cycle", 32'(v16), 0);

        // Abort at gate_cnt=50: no strobe, result holds, then a clean window
        repeat (49) tick();
        enable = 1'b0;
        tick();
        check("abort_busy", 32'(b16), 0);
        seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            tick();
            seen = seen | v16;
        end
        check("abort_no_valid", 32'(seen), 0);
        check("abort_fc16_hold", 32'(fc16), 10);
        enable = 1'b1;
        tick();
        check("reen_busy", 32'(b16), 1);
        wait_valid("reen", n);
        check("reen_cycles", n, 101);
        check("reen_fc16", 32'(fc16), 10);

        // Table: reprogram sig_in while idle, then two consecutive windows
        for (int k = 0; k < 8; k++) begin
            enable = 1'b0;
            period = vecs[k].period;
            repeat (30) tick();
            enable = 1'b1;
            tick();
            check($sformatf("v%0d_busy", k), 32'(b16), 1);
            wait_valid($sformatf("v%0d_a", k), n);
            check($sformatf("v%0d_a_cycles", k), n, 101);
            check($sformatf("v%0d_a_fc16", k), 32'(fc16), vecs[k].exp16);
            check($sformatf("v%0d_a_o16", k),  32'(o16),  0);
            check($sformatf("v%0d_a_v3", k),   32'(v3),   1);
            check($sformatf("v%0d_a_fc3", k),  32'(fc3),  vecs[k].exp3);
            check($sformatf("v%0d_a_o3", k),   32'(o3),   vecs[k].ovf3);
            wait_valid($sformatf("v%0d_b", k), n);
            check($sformatf("v%0d_b_cycles", k), n, 101);
            check($sformatf("v%0d_b_fc16", k), 32'(fc16), vecs[k].exp16);
            check($sformatf("v%0d_b_o3", k),   32'(o3),   vecs[k].ovf3);
        end

        // Reset pulse at gate_cnt=60, then the first window after release
        repeat (60) tick();
        check("mid_busy_before", 32'(b16), 1);
        reset = 1'b1;
        #1;
        check_reset_outputs("mid");
        repeat (3) tick();
        check_reset_outputs("mid_hold");
        release_aligned();
        tick();
        check("mid_busy_after_release", 32'(b16), 1);
        wait_valid("mid", n);
        check("mid_cycles", n, 101);
        check("mid_fc16", 32'(fc16), 10);
        check("mid_fc3",  32'(fc3),  7);
        check("mid_o3",   32'(o3),   1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
